// File: rtl/cnt_ctrl_pkg.sv
// Shared definitions for the timer count-enable generator: divider mode
// encodings and the prescaler terminal-count (limit) calculation.
package cnt_ctrl_pkg;

  localparam logic DIV_MODE_POW2   = 1'b0;
  localparam logic DIV_MODE_LINEAR = 1'b1;

  // Limits are computed at this fixed width; prescaler widths up to 32 bits fit.
  localparam int unsigned LIM_W = 32;

  // POW2 clamps the exponent to the prescaler width, so an oversized divisor
  // saturates at the longest period the counter can express (all ones).
  function automatic logic [LIM_W-1:0] calc_limit(
    input logic             mode,
    input logic [LIM_W-1:0] val,
    input int unsigned      div_w
  );
    logic [LIM_W-1:0] e;
    logic [LIM_W-1:0] lim;
    e   = '0;
    lim = '0;
    if (mode == DIV_MODE_LINEAR) begin
      lim = val;
    end else begin
      e = (val < div_w) ? val : div_w;
      if (e >= LIM_W) begin
        lim = '1;
      end else begin
        lim = (LIM_W'(1) << e) - LIM_W'(1);
      end
    end
    return lim;
  endfunction

endpackage

// File: rtl/cnt_ctrl_ch.sv
// One channel of the count-enable generator: prescaler counter, terminal
// detect, debug-halt freeze with registered acknowledge, and the cnt_en strobe.
module cnt_ctrl_ch
  import cnt_ctrl_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_timer_en,
  input  logic             i_div_en,
  input  logic             i_div_mode,
  input  logic [DIV_W-1:0] i_div_val,
  input  logic             i_halt_req,
  input  logic             i_dbg_mode,
  input  logic             i_sync_start,
  output logic             o_cnt_en,
  output logic             o_halt_ack
);

  logic [DIV_W-1:0] r_pcnt;
  logic [DIV_W-1:0] w_pcnt_nxt;
  logic [LIM_W-1:0] w_limit;
  logic             w_halted;
  logic             w_term;
  logic             w_clear;
  logic             r_halt_ack;

  assign w_halted = i_halt_req & i_dbg_mode;
  assign w_limit  = calc_limit(i_div_mode, LIM_W'(i_div_val), DIV_W);

  // '>=' rather than '==': a limit lowered below the running count fires on the
  // next evaluation instead of wrapping all the way round the counter.
  assign w_term   = (LIM_W'(r_pcnt) >= w_limit);
  assign w_clear  = ~i_timer_en | ~i_div_en | i_sync_start;

  // sync_start wins over halt for the clear; the freeze resumes afterwards.
  always_comb begin
    w_pcnt_nxt = r_pcnt;
    if (w_clear) begin
      w_pcnt_nxt = '0;
    end else if (w_halted) begin
      w_pcnt_nxt = r_pcnt;
    end else if (w_term) begin
      w_pcnt_nxt = '0;
    end else begin
      w_pcnt_nxt = r_pcnt + DIV_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pcnt     <= '0;
      r_halt_ack <= 1'b0;
    end else begin
      r_pcnt     <= w_pcnt_nxt;
      r_halt_ack <= w_halted;
    end
  end

  assign o_cnt_en   = ~w_halted & ~i_sync_start & i_timer_en & (i_div_en ? w_term : 1'b1);
  assign o_halt_ack = r_halt_ack;

endmodule

// File: rtl/cnt_ctrl_mc.sv
// Multi-channel count-enable generator for the timer block: NUM_CH independent
// prescaler channels sharing only the debug-mode and phase-align restart inputs.
module cnt_ctrl_mc
  import cnt_ctrl_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [NUM_CH-1:0]       timer_en,
  input  logic [NUM_CH-1:0]       div_en,
  input  logic [NUM_CH-1:0]       div_mode,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       halt_req,
  input  logic                    dbg_mode,
  input  logic                    sync_start,
  output logic [NUM_CH-1:0]       cnt_en,
  output logic [NUM_CH-1:0]       halt_ack
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    cnt_ctrl_ch #(
      .DIV_W (DIV_W)
    ) u_ch (
      .i_clk        (sys_clk),
      .i_rst_n      (sys_rst_n),
      .i_timer_en   (timer_en[g]),
      .i_div_en     (div_en[g]),
      .i_div_mode   (div_mode[g]),
      .i_div_val    (div_val[g*DIV_W +: DIV_W]),
      .i_halt_req   (halt_req[g]),
      .i_dbg_mode   (dbg_mode),
      .i_sync_start (sync_start),
      .o_cnt_en     (cnt_en[g]),
      .o_halt_ack   (halt_ack[g])
    );
  end

endmodule

// File: tb/tb_cnt_ctrl_mc.sv
// Randomized and directed checks of cnt_ctrl_mc against a cycle-level
// behavioural model of the prescaler/halt rules.
module tb_cnt_ctrl_mc;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;

  logic                    sys_clk = 1'b0;
  logic                    sys_rst_n;
  logic [NUM_CH-1:0]       timer_en;
  logic [NUM_CH-1:0]       div_en;
  logic [NUM_CH-1:0]       div_mode;
  logic [NUM_CH*DIV_W-1:0] div_val;
  logic [NUM_CH-1:0]       halt_req;
  logic                    dbg_mode;
  logic                    sync_start;
  logic [NUM_CH-1:0]       cnt_en;
  logic [NUM_CH-1:0]       halt_ack;

  int n_vec = 0;
  int n_err = 0;
  int pc_m    [NUM_CH];
  bit ack_m   [NUM_CH];
  int strobes [NUM_CH];

  cnt_ctrl_mc #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .timer_en   (timer_en),
    .div_en     (div_en),
    .div_mode   (div_mode),
    .div_val    (div_val),
    .halt_req   (halt_req),
    .dbg_mode   (dbg_mode),
    .sync_start (sync_start),
    .cnt_en     (cnt_en),
    .halt_ack   (halt_ack)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Terminal count from the divisor rules: period 2^min(v,DIV_W) or v+1.
  function automatic int lim_of(input int ch);
    int v;
    int e;
    v = int'(div_val[ch*DIV_W +: DIV_W]);
    if (v == 0) return 0;
    if (div_mode[ch]) return v;
    e = (v < DIV_W) ? v : DIV_W;
    return (1 << e) - 1;
  endfunction

  // Check the current cycle against the model, advance the model, move to the
  // next cycle. Inputs are driven by the caller before each call.
  task automatic step_n(input int n);
    logic [NUM_CH-1:0] e_en;
    logic [NUM_CH-1:0] e_ack;
    bit halted;
    bit term;
    repeat (n) begin
      #1;
      if (!sys_rst_n) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          pc_m[ch]  = 0;
          ack_m[ch] = 1'b0;
        end
      end
      for (int ch = 0; ch < NUM_CH; ch++) begin
        halted    = halt_req[ch] && dbg_mode;
        term      = (pc_m[ch] >= lim_of(ch));
        e_en[ch]  = !halted && !sync_start && timer_en[ch] && (div_en[ch] ? term : 1'b1);
        e_ack[ch] = ack_m[ch];
        if (sys_rst_n) begin
          if (!timer_en[ch] || !div_en[ch] || sync_start) pc_m[ch] = 0;
          else if (halted)                                 pc_m[ch] = pc_m[ch];
          else if (term)                                   pc_m[ch] = 0;
          else                                             pc_m[ch] = pc_m[ch] + 1;
          ack_m[ch] = halted;
        end
      end
      check_val("cnt_en", 32'(cnt_en), 32'(e_en));
      check_val("halt_ack", 32'(halt_ack), 32'(e_ack));
      for (int ch = 0; ch < NUM_CH; ch++) strobes[ch] += int'(cnt_en[ch]);
      @(negedge sys_clk);
      #1;
    end
  endtask

  task automatic set_ch(input int ch, input bit ten, input bit den, input bit mode, input int val);
    timer_en[ch] = ten;
    div_en[ch]   = den;
    div_mode[ch] = mode;
    div_val[ch*DIV_W +: DIV_W] = DIV_W'(val);
  endtask

  task automatic clr_strobes();
    for (int ch = 0; ch < NUM_CH; ch++) strobes[ch] = 0;
  endtask

  initial begin
    sys_rst_n  = 1'b0;
    timer_en   = '0;
    div_en     = '0;
    div_mode   = '0;
    div_val    = '0;
    halt_req   = '0;
    dbg_mode   = 1'b0;
    sync_start = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      pc_m[ch]  = 0;
      ack_m[ch] = 1'b0;
    end
    clr_strobes();
    #2;
    step_n(2);
    sys_rst_n = 1'b1;
    step_n(2);

    // Bypass: strobe every cycle, no ack.
    set_ch(0, 1, 0, 0, 0);
    clr_strobes();
    step_n(5);
    check_val("t1_bypass_cnt", 32'(strobes[0]), 32'd5);
    set_ch(0, 0, 0, 0, 0);

    // POW2 div 3: strobes at t+7, t+15, t+23.
    set_ch(1, 1, 1, 0, 3);
    clr_strobes();
    step_n(7);
    check_val("t2_pow2_first", 32'(strobes[1]), 32'd0);
    step_n(17);
    check_val("t2_pow2_3", 32'(strobes[1]), 32'd3);
    set_ch(1, 0, 1, 0, 3);
    step_n(1);
    // Oversized exponent clamps to period 256.
    set_ch(1, 1, 1, 0, 12);
    clr_strobes();
    step_n(255);
    check_val("t2_clamp_first", 32'(strobes[1]), 32'd0);
    step_n(1);
    check_val("t2_clamp_at255", 32'(strobes[1]), 32'd1);
    step_n(256);
    check_val("t2_clamp_period", 32'(strobes[1]), 32'd2);
    set_ch(1, 0, 0, 0, 0);

    // LINEAR 4, lowered to 1 while pcnt=3.
    set_ch(2, 1, 1, 1, 4);
    step_n(3);
    set_ch(2, 1, 1, 1, 1);
    clr_strobes();
    step_n(1);
    check_val("t3_lowered", 32'(strobes[2]), 32'd1);
    step_n(4);
    check_val("t3_period2", 32'(strobes[2]), 32'd3);
    set_ch(2, 0, 0, 0, 0);

    // Halt at pcnt=5 for 10 cycles, resume 4 cycles before the strobe.
    dbg_mode = 1'b1;
    set_ch(3, 1, 1, 1, 9);
    step_n(5);
    halt_req[3] = 1'b1;
    clr_strobes();
    step_n(10);
    check_val("t4_halted", 32'(strobes[3]), 32'd0);
    halt_req[3] = 1'b0;
    step_n(4);
    check_val("t4_resume_gap", 32'(strobes[3]), 32'd0);
    step_n(1);
    check_val("t4_resume_strobe", 32'(strobes[3]), 32'd1);
    set_ch(3, 0, 1, 1, 9);
    step_n(1);
    dbg_mode = 1'b0;
    set_ch(3, 1, 1, 1, 9);
    step_n(5);
    halt_req[3] = 1'b1;
    clr_strobes();
    step_n(10);
    check_val("t4_nodbg_runs", 32'(strobes[3]), 32'd1);
    halt_req[3] = 1'b0;

    // Phase-align restart across channels.
    set_ch(0, 1, 1, 0, 2);
    set_ch(1, 1, 1, 1, 6);
    set_ch(2, 1, 1, 1, 0);
    set_ch(3, 1, 1, 0, 4);
    step_n(7);
    sync_start = 1'b1;
    clr_strobes();
    step_n(1);
    check_val("t5_sync_quiet", 32'(strobes[0] + strobes[1] + strobes[2] + strobes[3]), 32'd0);
    sync_start = 1'b0;
    step_n(1);
    check_val("t5_div0_next", 32'(strobes[2]), 32'd1);
    check_val("t5_ch0_aligned", 32'(strobes[0]), 32'd0);

    // Async reset mid-count and mid-halt, then restart from zero.
    dbg_mode = 1'b1;
    set_ch(3, 1, 1, 1, 9);
    halt_req[3] = 1'b1;
    step_n(3);
    sys_rst_n = 1'b0;
    timer_en  = '0;
    step_n(2);
    sys_rst_n   = 1'b1;
    halt_req[3] = 1'b0;
    set_ch(3, 1, 1, 1, 9);
    clr_strobes();
    step_n(9);
    check_val("t6_restart_gap", 32'(strobes[3]), 32'd0);
    step_n(1);
    check_val("t6_restart_strobe", 32'(strobes[3]), 32'd1);

    // Randomized traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if ($urandom_range(63) == 0)
          set_ch(ch, $urandom_range(3) != 0, $urandom_range(3) != 0, 1'($urandom_range(1)),
                 ($urandom_range(7) == 0) ? int'($urandom_range(255)) : int'($urandom_range(10)));
        if ($urandom_range(15) == 0) halt_req[ch] = ~halt_req[ch];
      end
      if ($urandom_range(49) == 0) dbg_mode = ~dbg_mode;
      sync_start = ($urandom_range(39) == 0);
      sys_rst_n  = ($urandom_range(599) != 0);
      step_n(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
